// File: rtl/hs32_wb_arbiter.sv
// Register-file write-back arbiter: the load unit and a 2-entry execute FIFO share one write port.
// Optional round-robin contention grant: define HS32_WB_RR_EN (default build is fixed load priority).
module hs32_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [3:0]  ex_addr_i,
  input  logic [31:0] ex_data_i,
  input  logic        ex_we1_i,
  input  logic        ex_we2_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [3:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_we1_i,
  output logic [3:0]  wp_addr_o,
  output logic [31:0] wp_data_o,
  output logic        wp_we1_o,
  output logic        wp_we2_o,
  output logic [15:0] pend_mask_o,
  output logic        busy_o
);

  logic [3:0]  addr_q [2];
  logic [31:0] data_q [2];
  logic        we1_q  [2];
  logic        we2_q  [2];
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;

  logic exCand;
  logic ldGrant;
  logic exGrant;
  logic bypass;
  logic push;
  logic pop;

  assign exCand     = (count_q != 2'd0) || ex_valid_i;
  assign ex_ready_o = !reset && (count_q != 2'd2);

`ifdef HS32_WB_RR_EN
  typedef enum logic {GNT_EX = 1'b0, GNT_LD = 1'b1} grant_e;
  grant_e lastGrant_q, lastGrant_d;
  logic   contended;

  // The reset value lets execute take the first contended cycle; sides then alternate.
  always_comb begin
    ldGrant     = 1'b0;
    exGrant     = 1'b0;
    lastGrant_d = lastGrant_q;
    contended   = ld_valid_i && exCand;
    if (!reset) begin
      if (contended) begin
        if (lastGrant_q == GNT_EX) begin
          exGrant     = 1'b1;
          lastGrant_d = GNT_LD;
        end else begin
          ldGrant     = 1'b1;
          lastGrant_d = GNT_EX;
        end
      end else begin
        ldGrant = ld_valid_i;
        exGrant = exCand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lastGrant_q <= GNT_EX;
    else       lastGrant_q <= lastGrant_d;
  end
`else
  always_comb begin
    ldGrant = 1'b0;
    exGrant = 1'b0;
    if (!reset) begin
      ldGrant = ld_valid_i;
      exGrant = exCand && !ld_valid_i;
    end
  end
`endif

  assign ld_ready_o = ldGrant;

  // A granted execute write with an empty FIFO skips the buffer entirely.
  assign bypass = exGrant && (count_q == 2'd0);
  assign push   = ex_valid_i && ex_ready_o && !bypass;
  assign pop    = exGrant && (count_q != 2'd0);

  always_comb begin
    wp_addr_o = 4'd0;
    wp_data_o = 32'd0;
    wp_we1_o  = 1'b0;
    wp_we2_o  = 1'b0;
    if (ldGrant) begin
      wp_addr_o = ld_addr_i;
      wp_data_o = ld_data_i;
      wp_we1_o  = ld_we1_i;
    end else if (pop) begin
      wp_addr_o = addr_q[head_q];
      wp_data_o = data_q[head_q];
      wp_we1_o  = we1_q[head_q];
      wp_we2_o  = we2_q[head_q];
    end else if (bypass) begin
      wp_addr_o = ex_addr_i;
      wp_data_o = ex_data_i;
      wp_we1_o  = ex_we1_i;
      wp_we2_o  = ex_we2_i;
    end
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 4'd0;
        data_q[i] <= 32'd0;
        we1_q[i]  <= 1'b0;
        we2_q[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) begin
        addr_q[tail_q] <= ex_addr_i;
        data_q[tail_q] <= ex_data_i;
        we1_q[tail_q]  <= ex_we1_i;
        we2_q[tail_q]  <= ex_we2_i;
      end
    end
  end

  // Only occupied slots contribute: the head when count>=1, the other slot when full.
  always_comb begin
    pend_mask_o = 16'd0;
    if (count_q != 2'd0) pend_mask_o[addr_q[head_q]] = 1'b1;
    if (count_q == 2'd2) pend_mask_o[addr_q[~head_q]] = 1'b1;
  end

  assign busy_o = (count_q != 2'd0);

endmodule

// File: tb/tb_hs32_wb_arbiter.sv
// Directed self-checking bench for hs32_wb_arbiter; also covers HS32_WB_RR_EN when defined.
module tb_hs32_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i, ex_we1_i, ex_we2_i;
  logic [3:0]  ex_addr_i;
  logic [31:0] ex_data_i;
  logic        ld_valid_i, ld_we1_i;
  logic [3:0]  ld_addr_i;
  logic [31:0] ld_data_i;
  logic        ex_ready_o, ld_ready_o;
  logic [3:0]  wp_addr_o;
  logic [31:0] wp_data_o;
  logic        wp_we1_o, wp_we2_o;
  logic [15:0] pend_mask_o;
  logic        busy_o;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  hs32_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_addr_i(ex_addr_i),
    .ex_data_i(ex_data_i), .ex_we1_i(ex_we1_i), .ex_we2_i(ex_we2_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .ld_we1_i(ld_we1_i),
    .wp_addr_o(wp_addr_o), .wp_data_o(wp_data_o), .wp_we1_o(wp_we1_o),
    .wp_we2_o(wp_we2_o), .pend_mask_o(pend_mask_o), .busy_o(busy_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs just after a rising edge; outputs settle before the checks.
  task automatic applyStimulus(input logic exV, input logic [3:0] exA, input logic [31:0] exD,
                               input logic exW1, input logic exW2, input logic ldV,
                               input logic [3:0] ldA, input logic [31:0] ldD, input logic ldW1);
    @(posedge clk);
    #1;
    ex_valid_i = exV; ex_addr_i = exA; ex_data_i = exD; ex_we1_i = exW1; ex_we2_i = exW2;
    ld_valid_i = ldV; ld_addr_i = ldA; ld_data_i = ldD; ld_we1_i = ldW1;
    #3;
  endtask

  initial begin
    reset = 1'b1;
    ex_valid_i = 1'b1; ex_addr_i = 4'd1; ex_data_i = 32'h1; ex_we1_i = 1'b1; ex_we2_i = 1'b1;
    ld_valid_i = 1'b1; ld_addr_i = 4'd2; ld_data_i = 32'h2; ld_we1_i = 1'b1;
    #3;
    checkOutput("rst_ex_ready", ex_ready_o, 0);
    checkOutput("rst_ld_ready", ld_ready_o, 0);
    checkOutput("rst_we1", wp_we1_o, 0);
    checkOutput("rst_we2", wp_we2_o, 0);
    checkOutput("rst_pend", pend_mask_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;

    // Lone execute write bypasses the FIFO
    applyStimulus(1, 4'd3, 32'h1234, 1, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("lone_addr", wp_addr_o, 3);
    checkOutput("lone_data", wp_data_o, 32'h1234);
    checkOutput("lone_we1", wp_we1_o, 1);
    checkOutput("lone_we2", wp_we2_o, 0);
    checkOutput("lone_ex_ready", ex_ready_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("lone_busy", busy_o, 0);
    checkOutput("idle_we1", wp_we1_o, 0);

`ifdef HS32_WB_RR_EN
    // Contended for four cycles: ex (bypass), ld, ex (from FIFO), ld
    applyStimulus(1, 4'd10, 32'hE10, 1, 0, 1, 4'd5, 32'hAAAA, 1);
    checkOutput("rr1_addr", wp_addr_o, 10);
    checkOutput("rr1_ld_ready", ld_ready_o, 0);
    applyStimulus(1, 4'd11, 32'hE11, 1, 0, 1, 4'd5, 32'hAAAA, 1);
    checkOutput("rr2_addr", wp_addr_o, 5);
    checkOutput("rr2_ld_ready", ld_ready_o, 1);
    applyStimulus(1, 4'd12, 32'hE12, 1, 0, 1, 4'd5, 32'hAAAA, 1);
    checkOutput("rr3_addr", wp_addr_o, 11);
    checkOutput("rr3_data", wp_data_o, 32'hE11);
    checkOutput("rr3_ld_ready", ld_ready_o, 0);
    applyStimulus(1, 4'd13, 32'hE13, 1, 0, 1, 4'd5, 32'hAAAA, 1);
    checkOutput("rr4_addr", wp_addr_o, 5);
    checkOutput("rr4_ld_ready", ld_ready_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("rr_full_pend", pend_mask_o, 16'h3000);
    checkOutput("rr_drain_addr", wp_addr_o, 12);
`else
    // Contention: load wins, execute drains from the FIFO next cycle
    applyStimulus(1, 4'd2, 32'hBBBB, 1, 1, 1, 4'd5, 32'hAAAA, 1);
    checkOutput("cont_addr", wp_addr_o, 5);
    checkOutput("cont_data", wp_data_o, 32'hAAAA);
    checkOutput("cont_we1", wp_we1_o, 1);
    checkOutput("cont_we2", wp_we2_o, 0);
    checkOutput("cont_ld_ready", ld_ready_o, 1);
    checkOutput("cont_ex_ready", ex_ready_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("cont_pend", pend_mask_o, 16'h0004);
    checkOutput("cont_busy", busy_o, 1);
    checkOutput("cont_ex_addr", wp_addr_o, 2);
    checkOutput("cont_ex_data", wp_data_o, 32'hBBBB);
    checkOutput("cont_ex_we2", wp_we2_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("cont_drained_busy", busy_o, 0);
    checkOutput("cont_drained_pend", pend_mask_o, 0);
    checkOutput("cont_drained_we1", wp_we1_o, 0);

    // Full FIFO: load blocks three cycles; entry 2 has both enables low
    applyStimulus(1, 4'd1, 32'h101, 1, 0, 1, 4'd8, 32'h1, 1);
    checkOutput("full1_ex_ready", ex_ready_o, 1);
    applyStimulus(1, 4'd2, 32'h102, 0, 0, 1, 4'd8, 32'h2, 1);
    checkOutput("full2_ex_ready", ex_ready_o, 1);
    checkOutput("full2_pend", pend_mask_o, 16'h0002);
    applyStimulus(1, 4'd7, 32'h107, 1, 1, 1, 4'd8, 32'h3, 1);
    checkOutput("full3_ex_ready", ex_ready_o, 0);
    checkOutput("full3_pend", pend_mask_o, 16'h0006);
    checkOutput("full3_ld_addr", wp_addr_o, 8);
    applyStimulus(1, 4'd7, 32'h107, 1, 1, 0, 4'd0, 32'h0, 0);
    checkOutput("drain1_addr", wp_addr_o, 1);
    checkOutput("drain1_data", wp_data_o, 32'h101);
    checkOutput("drain1_ex_ready", ex_ready_o, 0);
    applyStimulus(1, 4'd7, 32'h107, 1, 1, 0, 4'd0, 32'h0, 0);
    checkOutput("drain2_addr", wp_addr_o, 2);
    checkOutput("drain2_we1", wp_we1_o, 0);
    checkOutput("drain2_ex_ready", ex_ready_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("drain3_addr", wp_addr_o, 7);
    checkOutput("drain3_data", wp_data_o, 32'h107);
    checkOutput("drain3_we2", wp_we2_o, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("drain_done_busy", busy_o, 0);

    // Fill to two entries, then reset mid-flight
    applyStimulus(1, 4'd4, 32'h204, 1, 0, 1, 4'd8, 32'h5, 1);
    applyStimulus(1, 4'd9, 32'h209, 1, 0, 1, 4'd8, 32'h6, 1);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 1, 4'd8, 32'h7, 1);
    checkOutput("mid_busy", busy_o, 1);
    checkOutput("mid_pend", pend_mask_o, 16'h0210);
    checkOutput("mid_ex_ready", ex_ready_o, 0);
`endif
    reset = 1'b1;
    #1;
    checkOutput("midrst_we1", wp_we1_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_pend", pend_mask_o, 0);
    checkOutput("midrst_ld_ready", ld_ready_o, 0);
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("post_rst_we1", wp_we1_o, 0);
    checkOutput("post_rst_we2", wp_we2_o, 0);
    checkOutput("post_rst_busy", busy_o, 0);
    applyStimulus(0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("post_rst2_we1", wp_we1_o, 0);
    checkOutput("post_rst_ex_ready", ex_ready_o, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hs32_wb_arbiter.md
HS32_WB_ARBITER -- requirements
Module: hs32_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the port list below (clock and reset first).
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  execute stage presents a write-back.
- ex_ready_o  out  1  execute write accepted this cycle.
- ex_addr_i  in  4  execute destination register.
- ex_data_i  in  32  execute result.
- ex_we1_i  in  1  execute write-enable 1.
- ex_we2_i  in  1  execute write-enable 2.
- ld_valid_i  in  1  load unit presents a write-back.
- ld_ready_o  out  1  load write accepted this cycle.
- ld_addr_i  in  4  load destination register.
- ld_data_i  in  32  load data.
- ld_we1_i  in  1  load write-enable 1; load never drives write-enable 2.
- wp_addr_o  out  4  register file write address.
- wp_data_o  out  32  register file write data.
- wp_we1_o  out  1  register file write-enable 1.
- wp_we2_o  out  1  register file write-enable 2.
- pend_mask_o  out  16  one-hot OR of destination addresses held in the buffer.
- busy_o  out  1  buffer non-empty.

Function
REQ-002 The block SHALL commit at most one write to the register file per cycle.
REQ-003 Execute writes SHALL pass through a 2-entry in-order FIFO; entries hold addr, data, we1 and we2.
REQ-004 ex_ready_o SHALL be 1 when the registered FIFO count is less than 2. At count 2 it SHALL be 0, even if a pop occurs in the same cycle.
REQ-005 An accepted execute write SHALL be pushed into the FIFO, except under REQ-006.
REQ-006 Bypass: when the FIFO is empty, ex_valid_i=1 and the execute source wins the grant, the write SHALL commit combinationally in the same cycle (0-cycle latency) without being pushed.
REQ-007 The execute-side contender SHALL be the FIFO head when count>0, otherwise the bypass input. Execute writes SHALL never commit out of order.
REQ-008 Grant (fixed priority, default): a valid load SHALL always win. ld_ready_o SHALL equal ld_valid_i outside reset. A losing execute contender SHALL be retained (head stays, bypass input is pushed).
REQ-009 The wp_* outputs SHALL be combinational from the granted source. With no grant, wp_we1_o = wp_we2_o = 0, and wp_addr_o/wp_data_o are don't-care.
REQ-010 Count SHALL update as +1 on push-only, -1 on pop-only, and be unchanged on push and pop together. The head pointer SHALL wrap modulo 2.
REQ-011 pend_mask_o and busy_o SHALL be derived from registered FIFO contents only; bypassed writes SHALL not appear.
REQ-012 Execute entries with we1=we2=0 SHALL still occupy a slot and a commit cycle, preserving order.
REQ-013 The block SHALL NOT resolve load/execute write-after-write conflicts; upstream hazard logic uses pend_mask_o for that.

Reset
REQ-014 While reset is asserted, the following SHALL hold: count=0, both pointers=0, round-robin last-grant=execute, ex_ready_o=0, ld_ready_o=0, wp_we1_o=0, wp_we2_o=0, pend_mask_o=0, busy_o=0.
REQ-015 Reset asserted mid-operation SHALL discard all buffered writes without committing them.
REQ-016 The first grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-017 HS32_WB_RR_EN defined: when load and execute contend in the same cycle, the grant SHALL alternate using a last-grant flop. The flop updates only on contended cycles, and ld_ready_o is 1 only when the load is granted. Uncontended requests are granted immediately.
REQ-018 HS32_WB_RR_EN undefined: fixed load priority per REQ-008, and no last-grant flop is instantiated.

Verification
REQ-019 Lone execute: ex_valid_i=1, addr=3, data=0x1234, we1=1, FIFO empty -> same cycle wp_addr_o=3, wp_data_o=0x1234, wp_we1_o=1; busy_o stays 0.
REQ-020 Contention, fixed priority: ld (addr 5, 0xAAAA) and ex (addr 2, 0xBBBB) in the same cycle -> load commits; next cycle ex commits from FIFO; pend_mask_o=0x0004 between the two.
REQ-021 Full: load held valid 3 cycles while ex issues addr 1, then 2, then 7 -> ex_ready_o=0 on the third; after the load drops, commits follow in order 1, 2, then 7.
REQ-022 Reset mid-flight: count=2, assert reset -> immediately wp_we1_o=0, busy_o=0, pend_mask_o=0; after release, no stale write commits.
REQ-023 HS32_WB_RR_EN: load and ex both valid for 4 cycles -> grants alternate ex, ld, ex, ld starting from the reset last-grant.
